// File: rtl/noc_pkg.sv
// noc_pkg: NoC flit sizing helpers and the packetizer FSM state shared by the host ingress path.
package noc_pkg;

   localparam int X = 16;
   localparam int Y = 16;
   localparam int DATA_W = 256;
   localparam int PCK_NUM = 12;
   localparam int x_size = $clog2(X);
   localparam int y_size = $clog2(Y);
   localparam int TW = x_size + y_size + PCK_NUM + DATA_W;

   typedef enum logic [1:0] {STREAM, FLUSH, DONE} state_t;

   // Flit layout MSB..LSB: {pkt_no, dest_y, dest_x, data}
   function automatic int dest_x_lsb(int data_w);
      return data_w;
   endfunction

   function automatic int pkt_lsb(int xs, int ys, int data_w);
      return data_w + xs + ys;
   endfunction

   function automatic int flit_w(int xn, int yn, int pck, int data_w);
      return $clog2(xn) + $clog2(yn) + pck + data_w;
   endfunction

endpackage

// File: rtl/pci_rx_packetizer_if.sv
// pci_rx_packetizer_if: valid/ready word stream of parameterised width.
interface pci_rx_packetizer_if #(parameter int W = 8) ();

   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pci_rx_fifo2.sv
// pci_rx_fifo2: 2-entry register FIFO with synchronous active-high reset.
module pci_rx_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   logic [W-1:0] r_mem [2];
   logic         r_wr;
   logic         r_rd;
   logic [1:0]   r_cnt;
   logic         w_push;
   logic         w_pop;

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rd];
   assign o_full  = r_cnt[1];
   assign o_empty = r_cnt == 2'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr     <= 1'b0;
         r_rd     <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= ~r_wr;
         end
         if (w_pop)
            r_rd <= ~r_rd;
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/pci_rx_packetizer.sv
// pci_rx_packetizer: tags host words with round-robin NoC dest and packet number, injects them as flits.
// Define SKIP_HOST_PE_EN to keep node (0,0) out of the destination rotation.
module pci_rx_packetizer
   import noc_pkg::*;
#(
   parameter int X          = 16,
   parameter int Y          = 16,
   parameter int data_width = 256,
   parameter int pck_num    = 12,
   parameter int NUM_WORDS  = 8192
) (
   input  logic                 clk,
   input  logic                 rst,
   pci_rx_packetizer_if.slave   host,
   pci_rx_packetizer_if.master  noc,
   output logic                 o_done
);

   localparam int DW = $clog2(X) + $clog2(Y);
   localparam int TW_L = flit_w(X, Y, pck_num, data_width);
   localparam int CW = $clog2(NUM_WORDS + 1);
   localparam logic [DW-1:0] D_LAST = DW'(X * Y - 1);
`ifdef SKIP_HOST_PE_EN
   localparam logic [DW-1:0] D_START = DW'(1);
`else
   localparam logic [DW-1:0] D_START = '0;
`endif

   state_t             r_state;
   logic [pck_num-1:0] r_pkt;
   logic [DW-1:0]      r_d;
   logic [CW-1:0]      r_cnt;
   logic               r_done;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic [TW_L-1:0]    w_flit;

   // {dest_y, dest_x} is exactly the destination index, so r_d drops straight in
   assign w_flit     = {r_pkt, r_d, host.data};
   assign host.ready = (r_state == STREAM) & ~w_full & ~rst;
   assign noc.valid  = ~w_empty;
   assign w_push     = host.valid & host.ready;
   assign w_pop      = noc.valid & noc.ready;
   assign o_done     = r_done;

   pci_rx_fifo2 #(.W(TW_L)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_flit),
      .o_data  (noc.data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= STREAM;
         r_pkt   <= '0;
         r_d     <= D_START;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         if (w_push) begin
            r_pkt <= r_pkt + pck_num'(1);
            r_d   <= (r_d == D_LAST) ? D_START : r_d + DW'(1);
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(NUM_WORDS - 1))
               r_state <= FLUSH;
         end
         // A pop while not full drains the single remaining entry
         if (r_state == FLUSH && (w_empty || (w_pop && ~w_full))) begin
            r_state <= DONE;
            r_done  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pci_rx_packetizer.sv
// tb_pci_rx_packetizer: randomized directed steps checked against a queue-based flit model.
module tb_pci_rx_packetizer;
  localparam int X = 2;
  localparam int Y = 2;
  localparam int DW = 32;
  localparam int PN = 2;
  localparam int NW = 8;
  localparam int XS = $clog2(X);
  localparam int YS = $clog2(Y);
  localparam int TW = XS + YS + PN + DW;
`ifdef SKIP_HOST_PE_EN
  localparam int DS = 1;
`else
  localparam int DS = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_done;
  pci_rx_packetizer_if #(.W(DW)) host ();
  pci_rx_packetizer_if #(.W(TW)) noc ();
  pci_rx_packetizer #(
    .X(X), .Y(Y), .data_width(DW), .pck_num(PN), .NUM_WORDS(NW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .host   (host),
    .noc    (noc),
    .o_done (o_done)
  );
  always #5 clk = ~clk;
  logic [TW-1:0] q[$];
  int k;
  int popped;
  int tests = 0;
  int fails = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [TW-1:0] exp_flit(int n, logic [DW-1:0] dat);
    int dd;
    dd = DS + n % (X * Y - DS);
    return {PN'(n % (1 << PN)), (XS + YS)'(dd), dat};
  endfunction
  task automatic reset_dut();
    rst = 1'b1;
    host.valid = 1'b0;
    noc.ready = 1'b0;
    #1;
    chk("rst_o_ready", host.ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    k = 0;
    popped = 0;
    #1;
    chk("rst_w_valid", noc.valid, 1'b0);
    chk("rst_w_data", noc.data, '0);
    chk("rst_o_done", o_done, 1'b0);
    chk("rst_o_ready_after", host.ready, 1'b1);
  endtask
  task automatic cycle(input logic iv, input logic wr);
    logic [DW-1:0] dat;
    logic acc;
    logic pop;
    dat = $urandom;
    host.valid = iv;
    host.data = dat;
    noc.ready = wr;
    #1;
    chk("o_ready", host.ready, (k < NW && q.size() < 2));
    chk("w_valid", noc.valid, (q.size() > 0));
    if (q.size() > 0)
      chk("w_data", noc.data, q[0]);
    chk("o_done", o_done, (popped == NW));
    acc = iv && host.ready;
    pop = noc.valid && wr;
    @(posedge clk);
    if (pop && q.size() > 0) begin
      void'(q.pop_front());
      popped++;
    end
    if (acc) begin
      q.push_back(exp_flit(k, dat));
      k++;
    end
    @(negedge clk);
  endtask
  task automatic run_frame(input int iv_mode, input int wr_mode);
    for (int i = 0; i < 400 && popped < NW; i++)
      cycle(iv_mode == 0 ? 1'b1 : iv_mode == 1 ? 1'($urandom_range(0, 1)) : 1'(i % 2 == 0),
            wr_mode == 0 ? 1'b1 : wr_mode == 1 ? 1'($urandom_range(0, 1)) : 1'(i % 2 == 0));
    chk("frame_done", popped, NW);
    cycle(1'b0, 1'b1);
  endtask
  initial begin
    host.valid = 1'b0;
    host.data = '0;
    noc.ready = 1'b0;
    k = 0;
    popped = 0;
    @(negedge clk);
    reset_dut();
    cycle(1'b1, 1'b1);
    chk("first_dest", noc.data[DW +: XS + YS], (XS + YS)'(DS));
    chk("first_pkt", noc.data[DW + XS + YS +: PN], '0);
    run_frame(0, 0);
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 1'b1);
    chk("done_hold_flits", popped, NW);
    reset_dut();
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b0);
    chk("bp_full_ready", host.ready, 1'b0);
    chk("bp_queued", q.size(), 2);
    run_frame(0, 0);
    reset_dut();
    run_frame(2, 1);
    reset_dut();
    for (int i = 0; i < 100 && k < 4; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)));
    chk("mid_accepts", k, 4);
    reset_dut();
    run_frame(1, 1);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
